// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one active-low row per slot, samples the
// active-low columns, debounces whole frames and decodes a single key press
// into a binary code with held/release/multi-key status and optional repeat.
// Handshake: key_valid and key_release are single-cycle strobes with no
// ready; a consumer must sample them on the cycle they are high.
// ROWS must be at least 2 (row_out rotates a single low bit).
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int CODE_W         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_RATE    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_err,
  output logic              state_dbg
);

  localparam int FRAME_W = ROWS * COLS;
  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RD_W    = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int RR_W    = $clog2(REPEAT_RATE + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]    ROW_INIT  = ~ROWS'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [RD_W-1:0]    RD_MAX    = RD_W'(REPEAT_DELAY);
  localparam logic [RR_W-1:0]    RR_MAX    = RR_W'(REPEAT_RATE);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t               state;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [ROW_W-1:0]     row_idx;
  logic [FRAME_W-1:0]   work_frame;
  logic [FRAME_W-1:0]   frame_next;
  logic [FRAME_W-1:0]   prev_frame;
  logic [FRAME_W-1:0]   stable_frame;
  logic [MATCH_W-1:0]   match_cnt;
  logic [MATCH_W-1:0]   match_next;
  logic                 eval_tick;
  logic                 frame_done;
  logic [1:0]           bit_cnt;
  logic [CODE_W-1:0]    single_idx;
  logic                 is_none;
  logic                 is_single;
  logic                 is_multi;
  logic [RD_W-1:0]      rep_cnt;
  logic [RR_W-1:0]      rate_cnt;

  assign state_dbg  = state;
  assign frame_done = (slot_cnt == SLOT_LAST) && (row_idx == ROW_LAST);

  // Working frame with the row being sampled this cycle merged in.
  always_comb begin
    frame_next = work_frame;
    frame_next[int'(row_idx) * COLS +: COLS] = ~col_in;
  end

  // Slot timer, row pointer and rotating active-low row drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      row_idx    <= '0;
      row_out    <= ROW_INIT;
      work_frame <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt   <= '0;
      work_frame <= frame_next;
      if (row_idx == ROW_LAST) begin
        row_idx <= '0;
        row_out <= ROW_INIT;
      end else begin
        row_idx <= row_idx + 1'b1;
        row_out <= {row_out[ROWS-2:0], 1'b1};
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Saturating count of consecutive identical frames.
  always_comb begin
    match_next = MATCH_W'(1);
    if (frame_next == prev_frame) begin
      match_next = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 1'b1;
    end
  end

  // Frame debounce: a frame seen DEBOUNCE_SCANS times in a row becomes stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_frame   <= '0;
      stable_frame <= '0;
      match_cnt    <= '0;
      eval_tick    <= 1'b0;
    end else begin
      eval_tick <= 1'b0;
      if (frame_done) begin
        prev_frame <= frame_next;
        match_cnt  <= match_next;
        if (match_next == MATCH_MAX) begin
          stable_frame <= frame_next;
          eval_tick    <= 1'b1;
        end
      end
    end
  end

  // Classify the stable frame: key count (saturating at 2) and key index.
  always_comb begin
    bit_cnt    = 2'd0;
    single_idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (stable_frame[i]) begin
        if (bit_cnt != 2'd2) bit_cnt = bit_cnt + 2'd1;
        single_idx = CODE_W'(i);
      end
    end
  end

  assign is_none   = (bit_cnt == 2'd0);
  assign is_single = (bit_cnt == 2'd1);
  assign is_multi  = (bit_cnt == 2'd2);

  // Press/hold/release FSM; advances only on evaluate ticks, strobes last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      multi_err   <= 1'b0;
      rep_cnt     <= '0;
      rate_cnt    <= '0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (eval_tick) begin
        multi_err <= is_multi;
        case (state)
          IDLE: begin
            if (is_single) begin
              key_code  <= single_idx;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rep_cnt   <= '0;
              rate_cnt  <= '0;
              state     <= HELD;
            end
          end
          HELD: begin
            if (is_none || (is_single && (single_idx != key_code))) begin
              key_release <= 1'b1;
              key_held    <= 1'b0;
              state       <= IDLE;
            end else if (is_single && (REPEAT_DELAY > 0)) begin
              // Count up to the initial delay, then fire every REPEAT_RATE ticks.
              if (rep_cnt != RD_MAX) begin
                rep_cnt <= rep_cnt + 1'b1;
                if (rep_cnt + 1'b1 == RD_MAX) begin
                  key_valid <= 1'b1;
                  rate_cnt  <= '0;
                end
              end else if (rate_cnt + 1'b1 == RR_MAX) begin
                key_valid <= 1'b1;
                rate_cnt  <= '0;
              end else begin
                rate_cnt <= rate_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad contact model feeds two instances (repeat
// off and repeat 4/2); stimulus changes only on frame boundaries so a
// frame-level reference model predicts every key event and its cycle.
module tb_keypad_scanner;

  localparam int DEB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] pressed = '0;

  logic [3:0] col_a, col_b, row_a, row_b, code_a, code_b;
  logic valid_a, held_a, rel_a, multi_a, st_a;
  logic valid_b, held_b, rel_b, multi_b, st_b;

  keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4),
    .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(0), .REPEAT_RATE(10)) dut (
    .clk(clk), .rst(rst), .col_in(col_a), .row_out(row_a), .key_code(code_a),
    .key_valid(valid_a), .key_held(held_a), .key_release(rel_a),
    .multi_err(multi_a), .state_dbg(st_a));

  keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4),
    .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_rep (
    .clk(clk), .rst(rst), .col_in(col_b), .row_out(row_b), .key_code(code_b),
    .key_valid(valid_b), .key_held(held_b), .key_release(rel_b),
    .multi_err(multi_b), .state_dbg(st_b));

  // Keypad contacts: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_a = 4'hF;
    col_b = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_a[r]) col_a[c] = 1'b0;
        if (pressed[r*4+c] && !row_b[r]) col_b[c] = 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: entries are {release, valid, code}, with the cycle they must appear.
  logic [5:0] exp_a_q[$];
  logic [5:0] exp_b_q[$];
  int         tim_a_q[$];
  int         tim_b_q[$];

  // Reference model state, one slot per instance.
  logic [15:0] m_prev[2];
  int          m_match[2];
  int          m_rep[2];
  int          m_code[2];
  bit          m_held[2];
  bit          m_multi[2];
  int          rd_p[2] = '{0, 4};
  int          rr_p[2] = '{10, 2};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = '0; m_match[d] = 0; m_rep[d] = 0;
      m_code[d] = 0;  m_held[d] = 0;  m_multi[d] = 0;
    end
  endtask

  task automatic push_evt(input int d, input bit rel, input int code);
    logic [5:0] e;
    e = {rel, ~rel, 4'(code)};
    if (d == 0) begin exp_a_q.push_back(e); tim_a_q.push_back(cyc + 1); end
    else        begin exp_b_q.push_back(e); tim_b_q.push_back(cyc + 1); end
  endtask

  // One complete scan frame of pressed set f has just finished for instance d.
  task automatic model_frame(input int d, input logic [15:0] f);
    int n, k;
    if (f == m_prev[d]) m_match[d] = (m_match[d] < DEB) ? m_match[d] + 1 : DEB;
    else                m_match[d] = 1;
    m_prev[d] = f;
    if (m_match[d] == DEB) begin
      n = $countones(f);
      k = 0;
      for (int i = 0; i < 16; i++) if (f[i]) k = i;
      m_multi[d] = (n >= 2);
      if (!m_held[d]) begin
        if (n == 1) begin
          m_code[d] = k; m_held[d] = 1; m_rep[d] = 0;
          push_evt(d, 1'b0, k);
        end
      end else if (n == 0 || (n == 1 && k != m_code[d])) begin
        m_held[d] = 0;
        push_evt(d, 1'b1, m_code[d]);
      end else if (n == 1) begin
        m_rep[d]++;
        if (rd_p[d] > 0 && (m_rep[d] == rd_p[d] ||
            (m_rep[d] > rd_p[d] && (m_rep[d] - rd_p[d]) % rr_p[d] == 0)))
          push_evt(d, 1'b0, m_code[d]);
      end
    end
  endtask

  // Monitor for the repeat-free instance.
  always @(negedge clk) begin
    if (!rst && (valid_a || rel_a)) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL evt_a: unexpected valid=%0b release=%0b code=%0d at cycle %0d",
                 valid_a, rel_a, code_a, cyc);
      end else begin
        check("evt_a", int'({rel_a, valid_a, code_a}), int'(exp_a_q.pop_front()));
        check("evt_a_cycle", cyc, tim_a_q.pop_front());
      end
    end
  end

  // Monitor for the repeating instance.
  always @(negedge clk) begin
    if (!rst && (valid_b || rel_b)) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL evt_b: unexpected valid=%0b release=%0b code=%0d at cycle %0d",
                 valid_b, rel_b, code_b, cyc);
      end else begin
        check("evt_b", int'({rel_b, valid_b, code_b}), int'(exp_b_q.pop_front()));
        check("evt_b_cycle", cyc, tim_b_q.pop_front());
      end
    end
  end

  task automatic check_status();
    check("held_a",  held_a,  m_held[0]);
    check("state_a", st_a,    m_held[0]);
    check("multi_a", multi_a, m_multi[0]);
    check("code_a",  code_a,  m_code[0]);
    check("held_b",  held_b,  m_held[1]);
    check("multi_b", multi_b, m_multi[1]);
    check("code_b",  code_b,  m_code[1]);
  endtask

  task automatic check_reset_outputs();
    check("rst_row_a", row_a, 4'b1110);
    check("rst_row_b", row_b, 4'b1110);
    check("rst_outs_a", int'({code_a, valid_a, held_a, rel_a, multi_a}), 0);
    check("rst_outs_b", int'({code_b, valid_b, held_b, rel_b, multi_b}), 0);
  endtask

  // Holds pressed set p for one frame; starts and ends on a negedge at a frame boundary.
  task automatic run_frame(input logic [15:0] p, input bit chk_rows);
    logic [3:0] exp_row;
    pressed = p;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) check_status();
      if (chk_rows && (i % 4 == 0)) begin
        exp_row = ~(4'b0001 << ((i / 4) % 4));
        check("row_seq", row_a, exp_row);
      end
    end
    model_frame(0, p);
    model_frame(1, p);
  endtask

  task automatic run_frames(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) run_frame(p, 1'b0);
  endtask

  initial begin
    logic [15:0] p;
    int a, b;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Idle frames with row drive sequence checks.
    run_frame(16'h0000, 1'b1);
    run_frame(16'h0000, 1'b1);

    // Clean press of row2/col1 (code 9), then release.
    run_frames(16'h0001 << 9, 6);
    run_frames(16'h0000, 3);

    // Bouncing row0/col0 contact, then a steady hold.
    for (int i = 0; i < 4; i++) run_frame((i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0);
    run_frames(16'h0001, 4);
    run_frames(16'h0000, 3);

    // Two keys together, then drop one.
    run_frames((16'h0001 << 3) | (16'h0001 << 12), 4);
    run_frames(16'h0001 << 3, 4);
    run_frames(16'h0000, 3);

    // Long hold of code 5 for auto-repeat.
    run_frames(16'h0001 << 5, 13);
    run_frames(16'h0000, 3);

    // Random segments of none / single / double presses.
    for (int s = 0; s < 14; s++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 2))
        0:       p = 16'h0000;
        1:       p = 16'h0001 << a;
        default: p = (16'h0001 << a) | (16'h0001 << b);
      endcase
      run_frames(p, $urandom_range(1, 4));
    end

    // Mid-scan reset with a key held: outputs clear at once, no event on exit.
    run_frames(16'h0001 << 9, 4);
    pressed = 16'h0001 << 9;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame(16'h0001 << 9, 1'b1);
    run_frames(16'h0001 << 9, 3);
    run_frames(16'h0000, 3);

    check("pending_a", exp_a_q.size(), 0);
    check("pending_b", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
